// File: rtl/series_adder_pkg.sv
// Shared constants and state encoding for the series adder stream packer.
package series_adder_pkg;

  localparam int WORD_W   = 32;
  localparam int RESULT_W = 40;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/series_adder_stream_packer.sv
// Packs an AXI-Stream frame of up to M words into one wide word with a
// valid/ready hand-off; flags short frames and drains the tail of long ones.
module series_adder_stream_packer
  import series_adder_pkg::*;
#(
  parameter int M = 8,
  parameter int W = WORD_W
) (
  input  logic           clk,
  input  logic           rst_p,
  input  logic [W-1:0]   s_tdata,
  input  logic           s_tvalid,
  input  logic           s_tlast,
  output logic           s_tready,
  output logic [M*W-1:0] data_o,
  output logic           data_vld,
  input  logic           data_rdy,
  output logic           err_short,
  output logic           err_long
);

  localparam int IDX_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             long_flag;
  logic             last_lane;

  // Ready is a pure function of state so the first post-reset cycle accepts.
  assign s_tready  = !rst_p && (state != FULL);
  assign last_lane = (idx == IDX_LAST);

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state     <= COLLECT;
      idx       <= '0;
      long_flag <= 1'b0;
      data_o    <= '0;
      data_vld  <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      // NOTE: error pulses default low every cycle, so any set below lasts exactly one cycle.
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        COLLECT: begin
          if (s_tvalid) begin
            data_o[idx*W +: W] <= s_tdata;
            if (last_lane || s_tlast) begin
              state     <= FULL;
              data_vld  <= 1'b1;
              idx       <= '0;
              err_short <= s_tlast && !last_lane;
              err_long  <= last_lane && !s_tlast;
              long_flag <= last_lane && !s_tlast;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        FULL: begin
          if (data_rdy) begin
            data_vld <= 1'b0;
            data_o   <= '0;
            idx      <= '0;
            state    <= long_flag ? DRAIN : COLLECT;
          end
        end
        DRAIN: begin
          // Overflow beats are dropped until the producer closes its frame.
          if (s_tvalid && s_tlast) begin
            state     <= COLLECT;
            long_flag <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_series_adder_stream_packer.sv
// Directed table-driven and scoreboard checks for series_adder_stream_packer (M=8, W=32).
module tb_series_adder_stream_packer;

  localparam int M = 8;
  localparam int W = 32;
  localparam int TIMEOUT = 100;

  logic           clk = 1'b0;
  logic           rst_p = 1'b1;
  logic [W-1:0]   s_tdata = '0;
  logic           s_tvalid = 1'b0;
  logic           s_tlast = 1'b0;
  logic           s_tready;
  logic [M*W-1:0] data_o;
  logic           data_vld;
  logic           data_rdy = 1'b0;
  logic           err_short;
  logic           err_long;

  int checks = 0;
  int failures = 0;
  int short_seen = 0;
  int long_seen = 0;
  int short_exp = 0;
  int long_exp = 0;

  series_adder_stream_packer #(.M(M), .W(W)) dut (
    .clk      (clk),
    .rst_p    (rst_p),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tlast  (s_tlast),
    .s_tready (s_tready),
    .data_o   (data_o),
    .data_vld (data_vld),
    .data_rdy (data_rdy),
    .err_short(err_short),
    .err_long (err_long)
  );

  always #5 clk = ~clk;

  // Count every error pulse cycle so spurious pulses anywhere are caught.
  always @(negedge clk) begin
    if (!rst_p) begin
      short_seen += int'(err_short);
      long_seen  += int'(err_long);
    end
  end

  typedef struct {
    int             base;
    int             n;
    logic [M*W-1:0] exp;
    bit             es;
    bit             el;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [M*W-1:0] act, input logic [M*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Entered and left just after a falling edge; holds the beat until accepted.
  task automatic send_beat(input int d, input bit last, input bit gaps);
    int n = 0;
    if (gaps) begin
      while ($urandom_range(1, 0) == 1 && n < 8) begin
        s_tvalid = 1'b0;
        s_tdata  = 32'hDEAD_BEEF;
        @(negedge clk);
        n++;
      end
    end
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d[W-1:0];
    s_tlast  = last;
    while (!s_tready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    if (n >= TIMEOUT) check("beat_accept_timeout", 1, 0);
    @(negedge clk);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic release_frame(input string name);
    data_rdy = 1'b1;
    @(negedge clk);
    data_rdy = 1'b0;
    check({name, "_vld_clear"}, data_vld, 0);
    check({name, "_data_clear"}, data_o, 0);
  endtask

  task automatic run_frame(input string name, input int base, input int n,
                           input logic [M*W-1:0] exp, input bit es, input bit el,
                           input bit gaps);
    int first = (n < M) ? n : M;
    for (int i = 0; i < first; i++) send_beat(base + i, i == n - 1, gaps);
    short_exp += int'(es);
    long_exp  += int'(el);
    check({name, "_vld"}, data_vld, 1);
    check({name, "_data"}, data_o, exp);
    check({name, "_err_short"}, err_short, es);
    check({name, "_err_long"}, err_long, el);
    @(negedge clk);
    check({name, "_pulse_end"}, {err_short, err_long, data_vld}, 3'b001);
    check({name, "_data_hold"}, data_o, exp);
    release_frame(name);
    for (int i = M; i < n; i++) send_beat(base + i, i == n - 1, gaps);
    check({name, "_idle"}, {data_vld, s_tready}, 2'b01);
  endtask

  function automatic logic [M*W-1:0] model(input int base, input int n);
    logic [M*W-1:0] r = '0;
    for (int k = 0; k < M && k < n; k++) r[k*W +: W] = base + k;
    return r;
  endfunction

  initial begin
    vecs[0] = '{1,   8,  {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 0, 0};
    vecs[1] = '{5,   3,  {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd7, 32'd6, 32'd5}, 1, 0};
    vecs[2] = '{1,   10, {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1}, 0, 1};
    vecs[3] = '{11,  8,  {32'd18, 32'd17, 32'd16, 32'd15, 32'd14, 32'd13, 32'd12, 32'd11}, 0, 0};
    vecs[4] = '{100, 1,  {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd100}, 1, 0};
    vecs[5] = '{40,  9,  {32'd47, 32'd46, 32'd45, 32'd44, 32'd43, 32'd42, 32'd41, 32'd40}, 0, 1};
    vecs[6] = '{50,  7,  {32'd0, 32'd56, 32'd55, 32'd54, 32'd53, 32'd52, 32'd51, 32'd50}, 1, 0};

    #1;
    check("reset_outputs", {s_tready, data_vld, err_short, err_long}, 4'b0000);
    check("reset_data", data_o, 0);
    @(negedge clk);
    rst_p = 1'b0;
    #1;
    check("ready_after_reset", s_tready, 1);
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      run_frame($sformatf("vec%0d", v), vecs[v].base, vecs[v].n, vecs[v].exp,
                vecs[v].es, vecs[v].el, 1'b0);

    // Consumer stalls 20 cycles while the producer keeps valid high.
    for (int i = 0; i < M; i++) send_beat(300 + i, i == M - 1, 1'b0);
    s_tvalid = 1'b1;
    s_tdata  = 32'd400;
    s_tlast  = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("stall_ready_low", s_tready, 0);
      check("stall_data_stable", data_o, model(300, M));
    end
    release_frame("stall");
    for (int i = 0; i < M; i++) send_beat(400 + i, i == M - 1, 1'b0);
    check("after_stall_data", data_o, model(400, M));
    check("after_stall_vld", data_vld, 1);
    release_frame("after_stall");

    // Reset mid-frame.
    for (int i = 0; i < 4; i++) send_beat(500 + i, 1'b0, 1'b0);
    rst_p = 1'b1;
    #1;
    check("midreset_outputs", {s_tready, data_vld, err_short, err_long}, 4'b0000);
    check("midreset_data", data_o, 0);
    @(negedge clk);
    rst_p = 1'b0;
    #1;
    check("midreset_ready", s_tready, 1);
    run_frame("post_reset", 21, 8, model(21, 8), 1'b0, 1'b0, 1'b0);

    // Reset while a long frame is pending in FULL.
    for (int i = 0; i < M; i++) send_beat(600 + i, 1'b0, 1'b0);
    long_exp++;
    check("full_before_reset", data_vld, 1);
    @(negedge clk);
    rst_p = 1'b1;
    #1;
    check("fullreset_outputs", {s_tready, data_vld, err_short, err_long}, 4'b0000);
    @(negedge clk);
    rst_p = 1'b0;
    #1;
    run_frame("post_full_reset", 31, 8, model(31, 8), 1'b0, 1'b0, 1'b0);

    // Random gaps and lengths against the scoreboard model.
    begin
      int base = 1000;
      for (int f = 0; f < 100; f++) begin
        int n = $urandom_range(10, 1);
        if ($urandom_range(1, 0) == 1) data_rdy = 1'b1;  // ignored while not valid
        @(negedge clk);
        data_rdy = 1'b0;
        run_frame($sformatf("rand%0d", f), base, n, model(base, n), n < M, n > M, 1'b1);
        base += 16;
      end
    end

    @(negedge clk);
    check("err_short_total", 32'(short_seen), 32'(short_exp));
    check("err_long_total", 32'(long_seen), 32'(long_exp));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/series_adder_stream_packer.md
SERIES_ADDER_STREAM_PACKER -- requirements
Module: series_adder_stream_packer

Interface
REQ-001 SHALL have parameter M, default 8: number of words per frame (M >= 1).
REQ-002 SHALL have parameter W, default 32: word width in bits.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_p  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port s_tdata  input  W: AXI-Stream slave data.
REQ-006 SHALL have port s_tvalid  input  1: AXI-Stream slave valid.
REQ-007 SHALL have port s_tlast  input  1: AXI-Stream end of frame.
REQ-008 SHALL have port s_tready  output  1: AXI-Stream slave ready.
REQ-009 SHALL have port data_o  output  M*W: packed frame; word k occupies bits [W*k+W-1 : W*k].
REQ-010 SHALL have port data_vld  output  1: data_o holds a complete frame.
REQ-011 SHALL have port data_rdy  input  1: consumer accepts the frame.
REQ-012 SHALL have port err_short  output  1: one-cycle pulse when the frame ended before M words.
REQ-013 SHALL have port err_long  output  1: one-cycle pulse when the M-th word arrived without s_tlast.

Function
REQ-014 SHALL count a beat as accepted only on a rising edge where s_tvalid and s_tready are both 1.
REQ-015 SHALL implement states COLLECT, FULL and DRAIN.
REQ-016 COLLECT: s_tready=1 and data_vld=0; each accepted beat writes lane idx and increments idx (0..M-1).
REQ-017 COLLECT: an accepted beat with idx==M-1 or s_tlast=1 SHALL move to FULL, with data_vld=1 in the next cycle (latency 1).
REQ-018 Short frame (s_tlast with idx<M-1): unwritten lanes SHALL read 0; err_short=1 in the first FULL cycle only.
REQ-019 Long frame (idx==M-1, s_tlast=0): err_long=1 in the first FULL cycle only; a long-frame flag SHALL be stored.
REQ-020 FULL: s_tready=0; data_o and data_vld SHALL stay stable until data_rdy=1.
REQ-021 FULL with data_rdy=1: next cycle data_vld=0, all lanes cleared to 0, idx=0; state becomes DRAIN if the long-frame flag is set, otherwise COLLECT.
REQ-022 DRAIN: s_tready=1; accepted beats SHALL be discarded; a beat with s_tlast=1 returns to COLLECT and clears the long-frame flag.
REQ-023 data_rdy SHALL be ignored when data_vld=0.
REQ-024 Gaps in s_tvalid SHALL neither lose nor duplicate words.
REQ-025 M=1: every accepted beat SHALL complete a frame; err_long only when s_tlast=0; err_short never.
REQ-026 idx SHALL be ceil(log2(M)) bits wide, minimum 1, and SHALL never exceed M-1.

Reset
REQ-027 While rst_p=1: s_tready, data_vld, err_short, err_long and data_o SHALL be 0; idx=0; long-frame flag=0; state=COLLECT.
REQ-028 s_tready SHALL be 1 in the first cycle after rst_p deasserts.
REQ-029 Reset mid-frame or in FULL/DRAIN SHALL discard the partial or pending frame without generating any error pulse.

Structure
REQ-030 SHALL place the word-width constant (32), the result-width constant (40) and the state enum typedef in the shared package series_adder_pkg.
REQ-031 SHALL be one module with no sub-modules; the lane write uses an indexed part-select of data_o.

Verification (M=8, W=32)
REQ-032 Beats 1..8, s_tlast on the 8th -> data_o lanes = 1..8, data_vld rises 1 cycle after the 8th beat, both error outputs stay 0.
REQ-033 Beats 5,6,7, s_tlast on the 3rd -> lanes = 5,6,7,0,0,0,0,0; err_short is a single-cycle pulse.
REQ-034 Beats 1..10, s_tlast on the 10th -> lanes = 1..8, err_long pulses once, beats 9 and 10 are discarded; the following frame 11..18 is packed correctly.
REQ-035 data_rdy held 0 for 20 cycles with s_tvalid=1 -> s_tready=0 and data_o unchanged throughout; no words are lost after release.
REQ-036 rst_p pulsed after 4 beats -> all outputs 0; the next frame 21..28 is packed correctly with no error pulse.
REQ-037 s_tvalid random at 50% duty over 100 frames -> every frame matches the scoreboard with zero mismatches.
